obi_mux_sched: RTL and testbench

OBI_MUX_SCHED -- requirements
Module: obi_mux_sched

---
 rtl/obi_mux_sched_if.sv | 30 +++
 rtl/obi_mux_sched.sv | 151 +++++++++++++++
 tb/tb_obi_mux_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_mux_sched_if.sv
// Bundles the requester and manager-side signals of the OBI request scheduler.
// Latency: none (wires only).
// Backpressure: carried by the req/gnt pairs; the mux never holds a grant without a request.
interface obi_mux_sched_if #(
    parameter int NumReq = 4
);
    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] gnt_o;
    logic              mgr_req_o;
    logic              mgr_gnt_i;
    logic [IdxW-1:0]   sel_idx_o;
    logic              rsp_done_i;
    logic [IdxW-1:0]   rsp_idx_i;
    logic [5:0]        outstanding_o;
    logic              err_o;

    // Scheduler side
    modport slave (
        input  req_i, mgr_gnt_i, rsp_done_i, rsp_idx_i,
        output gnt_o, mgr_req_o, sel_idx_o, outstanding_o, err_o
    );

    // Requesters plus manager port, seen from outside the scheduler
    modport master (
        output req_i, mgr_gnt_i, rsp_done_i, rsp_idx_i,
        input  gnt_o, mgr_req_o, sel_idx_o, outstanding_o, err_o
    );
endinterface

// File: rtl/obi_mux_sched.sv
// Round-robin OBI request mux with per-port and aggregate outstanding-transaction credits.
// Latency: zero-cycle grant pass-through; counters, pointer and error flag update on the next edge.
// Backpressure: a selection is held (LOCKED) until mgr_gnt_i; ports out of credit are not eligible.
module obi_mux_sched #(
    parameter int NumReq          = 4,
    parameter int MaxTransPerPort = 4,
    parameter int MaxTransTotal   = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    obi_mux_sched_if.slave bus
);
    localparam int IdxW = $clog2(NumReq);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Reject unsupported configurations at elaboration time
    if (NumReq < 2 || NumReq > 16) begin : g_bad_numreq
        $fatal(1, "obi_mux_sched: NumReq must be in 2..16");
    end
    if (MaxTransPerPort < 1 || MaxTransPerPort > 15) begin : g_bad_perport
        $fatal(1, "obi_mux_sched: MaxTransPerPort must be in 1..15");
    end
    if (MaxTransTotal < MaxTransPerPort || MaxTransTotal > 63) begin : g_bad_total
        $fatal(1, "obi_mux_sched: MaxTransTotal must be in MaxTransPerPort..63");
    end

    logic [0:0]      state_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] sel_q;
    logic [3:0]      cnt_q [NumReq];
    logic [5:0]      total_q;
    logic            err_q;

    logic [NumReq-1:0] elig;
    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cur_sel;
    logic              mgr_req;
    logic              hs;
    logic              abort;
    logic [NumReq-1:0] inc;
    logic [NumReq-1:0] dec;
    logic              dec_any;
    logic              bad_rsp;
    logic [NumReq-1:0] gnt;

    // Eligibility uses registered credits only, so a freed credit is usable the cycle after retirement
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            elig[i] = bus.req_i[i] && (cnt_q[i] < 4'(MaxTransPerPort))
                      && (total_q < 6'(MaxTransTotal));
        end
    end

    // First eligible port at or after rr_ptr, wrapping; descending scan so the nearest one wins
    always_comb begin
        int p;
        pick_vld = 1'b0;
        pick_idx = '0;
        p        = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            p = int'(rr_ptr_q) + k;
            if (p >= NumReq) p = p - NumReq;
            if (elig[p[IdxW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = p[IdxW-1:0];
            end
        end
    end

    // Manager request, handshake and grant steering; a port that withdrew its request is never granted
    always_comb begin
        if (state_q == ST_LOCKED) begin
            cur_sel = sel_q;
            mgr_req = !rst_i && bus.req_i[sel_q];
            abort   = !rst_i && !bus.req_i[sel_q];
        end else begin
            cur_sel = pick_vld ? pick_idx : sel_q;
            mgr_req = !rst_i && pick_vld;
            abort   = 1'b0;
        end
        hs = mgr_req && bus.mgr_gnt_i;
        for (int i = 0; i < NumReq; i++) begin
            gnt[i] = hs && (cur_sel == IdxW'(i));
        end
    end

    // Per-port credit events; a retirement that matches no busy port is a protocol error
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            inc[i] = hs && (cur_sel == IdxW'(i));
            dec[i] = bus.rsp_done_i && (bus.rsp_idx_i == IdxW'(i)) && (cnt_q[i] != 4'd0);
        end
        dec_any = |dec;
        bad_rsp = bus.rsp_done_i && !dec_any;
    end

    // FSM, round-robin pointer and held selection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
        end else begin
            sel_q <= cur_sel;
            if (hs) begin
                state_q  <= ST_IDLE;
                rr_ptr_q <= (cur_sel == IdxW'(NumReq - 1)) ? '0 : cur_sel + 1'b1;
            end else if (abort) begin
                state_q <= ST_IDLE;
            end else if (mgr_req) begin
                state_q <= ST_LOCKED;
            end
        end
    end

    // Saturating outstanding counters; same-port grant and retirement cancel out
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumReq; i++) cnt_q[i] <= 4'd0;
            total_q <= 6'd0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (inc[i] && !dec[i] && cnt_q[i] != 4'hF) begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - 4'd1;
                end
            end
            if (hs && !dec_any && total_q != 6'h3F) begin
                total_q <= total_q + 6'd1;
            end else if (dec_any && !hs) begin
                total_q <= total_q - 6'd1;
            end
        end
    end

    // One-cycle error pulse for abandoned requests and unmatched retirements
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= abort || bad_rsp;
    end

    assign bus.gnt_o         = gnt;
    assign bus.mgr_req_o     = mgr_req;
    assign bus.sel_idx_o     = cur_sel;
    assign bus.outstanding_o = total_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_obi_mux_sched.sv
module tb_obi_mux_sched;
    localparam int N   = 4;
    localparam int MPP = 4;
    localparam int MTT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obi_mux_sched_if #(.NumReq(N)) bus();

    obi_mux_sched #(.NumReq(N), .MaxTransPerPort(MPP), .MaxTransTotal(MTT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: outstanding transactions per port, pending-request lock, rotation pointer
    int m_cnt [N];
    int m_total;
    int m_rr;
    int m_last;
    int m_lsel;
    bit m_locked;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_total  = 0;
        m_rr     = 0;
        m_last   = 0;
        m_lsel   = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
    endtask

    // Apply one cycle of inputs, check the DUT against the model, then advance the model
    task automatic drive(input logic [3:0] req, input logic g, input logic d,
                         input logic [1:0] idx, input logic r);
        bit e_req;
        int e_sel;
        bit found;
        bit nerr;
        bit hs;
        logic [3:0] e_gnt;
        @(negedge clk);
        bus.req_i      = req;
        bus.mgr_gnt_i  = g;
        bus.rsp_done_i = d;
        bus.rsp_idx_i  = idx;
        rst            = r;
        #1;
        found = 1'b0;
        e_sel = m_last;
        if (m_locked) begin
            e_sel = m_lsel;
            e_req = req[m_lsel];
        end else begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_rr + k) % N;
                if (!found && req[p] && m_cnt[p] < MPP && m_total < MTT) begin
                    found = 1'b1;
                    e_sel = p;
                end
            end
            e_req = found;
        end
        if (r) e_req = 1'b0;
        hs    = e_req && g;
        e_gnt = hs ? 4'(1 << e_sel) : 4'd0;
        chk("mgr_req", 32'(bus.mgr_req_o), 32'(e_req));
        chk("gnt", 32'(bus.gnt_o), 32'(e_gnt));
        if (!r) chk("sel_idx", 32'(bus.sel_idx_o), 32'(e_sel));
        chk("outstanding", 32'(bus.outstanding_o), 32'(m_total));
        chk("err", 32'(bus.err_o), 32'(m_err));
        if (r) begin
            model_reset();
        end else begin
            nerr = 1'b0;
            if (m_locked && !req[m_lsel]) begin
                m_locked = 1'b0;
                nerr     = 1'b1;
            end else if (hs) begin
                m_locked = 1'b0;
                m_rr     = (e_sel + 1) % N;
            end else if (e_req) begin
                m_locked = 1'b1;
                m_lsel   = e_sel;
            end
            m_last = e_sel;
            if (d) begin
                if (int'(idx) >= N || m_cnt[idx] == 0) begin
                    nerr = 1'b1;
                end else begin
                    m_cnt[idx] = m_cnt[idx] - 1;
                    m_total    = m_total - 1;
                end
            end
            if (hs) begin
                m_cnt[e_sel] = m_cnt[e_sel] + 1;
                m_total      = m_total + 1;
            end
            m_err = nerr;
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       g;
        logic       d;
        logic [1:0] idx;
        logic       r;
        logic       e_req;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        logic       chk_sel;
        logic [5:0] e_out;
        logic       e_err;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic [3:0] req, input logic g, input logic d,
                                input logic [1:0] idx, input logic r, input logic e_req,
                                input logic [3:0] e_gnt, input logic [1:0] e_sel,
                                input logic chk_sel, input logic [5:0] e_out, input logic e_err);
        vec_t v;
        v.req = req; v.g = g; v.d = d; v.idx = idx; v.r = r;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_sel = e_sel; v.chk_sel = chk_sel;
        v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        int grants;
        logic [31:0] rv;

        //           req      g  d  idx r  mreq gnt      sel cs out err
        tbl[0]  = mk(4'b1111, 1, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
        // rotation 0,1,2,3,0 with each grant retired the next cycle
        tbl[1]  = mk(4'b1111, 1, 0, 0, 0, 1, 4'b0001, 0, 1, 0, 0);
        tbl[2]  = mk(4'b1111, 1, 1, 0, 0, 1, 4'b0010, 1, 1, 1, 0);
        tbl[3]  = mk(4'b1111, 1, 1, 1, 0, 1, 4'b0100, 2, 1, 1, 0);
        tbl[4]  = mk(4'b1111, 1, 1, 2, 0, 1, 4'b1000, 3, 1, 1, 0);
        tbl[5]  = mk(4'b1111, 1, 1, 3, 0, 1, 4'b0001, 0, 1, 1, 0);
        tbl[6]  = mk(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
        tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        // retirement on an idle port: error pulse, count stays 0
        tbl[8]  = mk(4'b0000, 0, 1, 3, 0, 0, 4'b0000, 0, 1, 0, 0);
        tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
        tbl[10] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        // lock on port 1 survives a new request from port 0
        tbl[11] = mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0);
        tbl[12] = mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0);
        tbl[13] = mk(4'b0010, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0);
        tbl[14] = mk(4'b0011, 0, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0);
        tbl[15] = mk(4'b0011, 1, 0, 0, 0, 1, 4'b0010, 1, 1, 0, 0);
        tbl[16] = mk(4'b0011, 1, 0, 0, 0, 1, 4'b0001, 0, 1, 1, 0);
        tbl[17] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 2, 0);
        tbl[18] = mk(4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 2, 0);
        tbl[19] = mk(4'b0000, 0, 1, 1, 0, 0, 4'b0000, 0, 1, 1, 0);
        tbl[20] = mk(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);

        bus.req_i      = '0;
        bus.mgr_gnt_i  = 1'b0;
        bus.rsp_done_i = 1'b0;
        bus.rsp_idx_i  = '0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].req, tbl[i].g, tbl[i].d, tbl[i].idx, tbl[i].r);
            chk($sformatf("vec%0d_mgr_req", i), 32'(bus.mgr_req_o), 32'(tbl[i].e_req));
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt_o), 32'(tbl[i].e_gnt));
            if (tbl[i].chk_sel) chk($sformatf("vec%0d_sel", i), 32'(bus.sel_idx_o), 32'(tbl[i].e_sel));
            chk($sformatf("vec%0d_out", i), 32'(bus.outstanding_o), 32'(tbl[i].e_out));
            chk($sformatf("vec%0d_err", i), 32'(bus.err_o), 32'(tbl[i].e_err));
        end

        // Single requester runs out of per-port credit after MPP grants
        drive(4'b0000, 0, 0, 0, 1);
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            drive(4'b0001, 1, 0, 0, 0);
            if (bus.gnt_o == 4'b0001) grants++;
        end
        chk("credit_grants", 32'(grants), 32'(MPP));
        chk("credit_mgr_req", 32'(bus.mgr_req_o), 32'd0);
        chk("credit_out", 32'(bus.outstanding_o), 32'(MPP));
        drive(4'b0001, 1, 1, 0, 0);
        chk("credit_no_bypass", 32'(bus.mgr_req_o), 32'd0);
        drive(4'b0001, 1, 0, 0, 0);
        chk("credit_resume", 32'(bus.gnt_o), 32'b0001);
        for (int c = 0; c < MPP; c++) drive(4'b0000, 0, 1, 0, 0);
        drive(4'b0000, 0, 0, 0, 0);
        chk("credit_drained", 32'(bus.outstanding_o), 32'd0);

        // Abandoned request while locked on port 2
        drive(4'b0100, 0, 0, 0, 0);
        chk("abort_lock_sel", 32'(bus.sel_idx_o), 32'd2);
        drive(4'b0000, 0, 0, 0, 0);
        drive(4'b0000, 0, 0, 0, 0);
        chk("abort_err", 32'(bus.err_o), 32'd1);
        chk("abort_out", 32'(bus.outstanding_o), 32'd0);
        drive(4'b0001, 0, 0, 0, 0);
        chk("abort_err_clear", 32'(bus.err_o), 32'd0);
        chk("abort_idle_sel", 32'(bus.sel_idx_o), 32'd0);
        drive(4'b0001, 1, 0, 0, 0);
        drive(4'b0000, 0, 1, 0, 0);

        // Same-cycle grant and retirement on port 1 with two outstanding
        drive(4'b0000, 0, 0, 0, 1);
        drive(4'b0010, 1, 0, 0, 0);
        drive(4'b0010, 1, 0, 0, 0);
        drive(4'b0010, 1, 1, 1, 0);
        drive(4'b0000, 0, 0, 0, 0);
        chk("same_port_cnt1", 32'(dut.cnt_q[1]), 32'd2);
        chk("same_port_total", 32'(bus.outstanding_o), 32'd2);

        // Reset in the middle of a locked request with five outstanding
        drive(4'b0000, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) drive(4'b1111, 1, 0, 0, 0);
        drive(4'b1111, 0, 0, 0, 0);
        chk("rst_pre_out", 32'(bus.outstanding_o), 32'd5);
        drive(4'b1111, 0, 0, 0, 1);
        chk("rst_mgr_req", 32'(bus.mgr_req_o), 32'd0);
        drive(4'b1111, 1, 0, 0, 1);
        chk("rst_out", 32'(bus.outstanding_o), 32'd0);
        chk("rst_mgr_req2", 32'(bus.mgr_req_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        drive(4'b1111, 1, 0, 0, 0);
        chk("rst_first_gnt", 32'(bus.gnt_o), 32'b0001);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rv = $urandom;
            drive(rv[3:0], rv[4] | rv[5], rv[8:6] < 3'd3, rv[10:9], rv[19:12] == 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
